demux_1n_stream: RTL

//  Parametrised 1-to-N stream demultiplexer with one registered holding stage.

---
 rtl/demux_1n_stream_pkg.sv | 20 ++
 rtl/demux_1n_stream_if.sv | 31 +++
 rtl/demux_1n_stream_onehot_dec.sv | 32 +++
 rtl/demux_1n_stream.sv | 77 +++++++
 4 files changed

// File: rtl/demux_1n_stream_pkg.sv
// Shared constants and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_SAT = {DROP_CNT_W{1'b1}};

    // Ceiling log2 for elaboration-time width derivation (n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_1n_stream_if.sv
// Single-producer input stream plus N per-channel output streams of the demux.
interface demux_1n_stream_if
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 8,
    parameter int unsigned SEL_W  = clog2(N_OUT)
);

    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;

    // Producer and consumer side (the testbench / surrounding fabric).
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // The demultiplexer itself.
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/demux_1n_stream_onehot_dec.sv
// Combinational select decoder: one-hot, all-ones for broadcast, empty plus drop flag when out of range.
module onehot_dec
    import demux_pkg::*;
#(
    parameter int unsigned N_OUT = 8,
    parameter int unsigned SEL_W = clog2(N_OUT)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             all,
    output logic [N_OUT-1:0] onehot,
    output logic             drop_c
);

    localparam logic [SEL_W:0] N_OUT_X = (SEL_W+1)'(N_OUT);

    logic in_range_c;

    assign in_range_c = ({1'b0, sel} < N_OUT_X);
    assign drop_c     = en & ~all & ~in_range_c;

    // Out-of-range sel matches no index, so it naturally decodes to zero.
    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (en && (all || (sel == SEL_W'(k)))) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1n_stream.sv
// 1-to-N stream demultiplexer with a single holding stage and per-channel retire.
module demux_1n_stream
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_OUT    = 8,
    parameter int unsigned SEL_W    = clog2(N_OUT),
    parameter int unsigned BCAST_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1n_stream_if.slave      bus,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  busy
);

    logic [DATA_W-1:0]     hold_data_q, hold_data_d;
    logic [N_OUT-1:0]      pending_q,   pending_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;
    logic                  busy_q,      busy_d;

    logic                  accept_c;
    logic                  bcast_c;
    logic                  drop_c;
    logic [N_OUT-1:0]      dest_mask_c;

    // Ready whenever every still-owed channel takes its beat this cycle.
    assign bus.in_ready = ((pending_q & ~bus.out_ready) == '0);
    assign accept_c     = bus.in_valid & bus.in_ready;
    assign bcast_c      = bus.in_bcast & (BCAST_EN != 0);

    onehot_dec #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel    (bus.in_sel),
        .en     (accept_c),
        .all    (bcast_c),
        .onehot (dest_mask_c),
        .drop_c (drop_c)
    );

    // Next state: retire per channel, a new accept overwrites the whole mask.
    always_comb begin
        hold_data_d = hold_data_q;
        pending_d   = pending_q & ~bus.out_ready;
        drop_cnt_d  = drop_cnt_q;
        if (accept_c) begin
            hold_data_d = bus.in_data;
            pending_d   = dest_mask_c;
            if (drop_c && (drop_cnt_q != DROP_SAT)) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
        busy_d = (pending_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q <= '0;
            pending_q   <= '0;
            drop_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            pending_q   <= pending_d;
            drop_cnt_q  <= drop_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.out_valid = pending_q;
    assign bus.out_data  = {N_OUT{hold_data_q}};
    assign drop_cnt      = drop_cnt_q;
    assign busy          = busy_q;

endmodule
